// File: rtl/umi_arb_pkg.sv
// ============================================================================
// Module : umi_arb_pkg
// Brief  : Shared state encoding and UMI opcode constants for the adder arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package umi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_RESP = 2'd2,
        RESP      = 2'd3
    } arb_state_t;

    localparam logic [4:0] UMI_REQ_RD     = 5'h01;
    localparam logic [4:0] UMI_REQ_WR     = 5'h03;
    localparam logic [4:0] UMI_REQ_POSTED = 5'h05;

endpackage

`default_nettype wire

// File: rtl/umi_rr_pick.sv
// ============================================================================
// Module : umi_rr_pick
// Brief  : Combinational round-robin picker: first valid index at or after ptr.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module umi_rr_pick #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  i_valid,
    input  logic [PW-1:0] i_ptr,
    output logic [PW-1:0] o_idx,
    output logic          o_any
);

    // Smallest forward distance from the pointer wins; wrap is N-1 -> 0.
    always_comb begin : p_pick
        int w_best;
        int w_dist;
        w_best = N;
        w_dist = 0;
        o_idx  = '0;
        for (int j = 0; j < N; j++) begin
            w_dist = (j >= int'(i_ptr)) ? (j - int'(i_ptr)) : (j + N - int'(i_ptr));
            if (i_valid[j] && (w_dist < w_best)) begin
                w_best = w_dist;
                o_idx  = PW'(j);
            end
        end
    end

    assign o_any = |i_valid;

endmodule

`default_nettype wire

// File: rtl/umi_adder_arbiter.sv
// ============================================================================
// Module : umi_adder_arbiter
// Brief  : Round-robin sharing of one adder_core UMI port among N hosts, with
//          response routing to the lock owner and a watchdog on the response.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module umi_adder_arbiter
    import umi_arb_pkg::*;
#(
    parameter int N       = 2,
    parameter int DW      = 32,
    parameter int AW      = 64,
    parameter int CW      = 32,
    parameter int TOW     = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic                   clk,
    input  logic                   nreset,
    input  logic [N-1:0]           udev_req_valid,
    output logic [N-1:0]           udev_req_ready,
    input  logic [N*CW-1:0]        udev_req_cmd,
    input  logic [N*AW-1:0]        udev_req_dstaddr,
    input  logic [N*AW-1:0]        udev_req_srcaddr,
    input  logic [N*DW-1:0]        udev_req_data,
    output logic [N-1:0]           udev_resp_valid,
    input  logic [N-1:0]           udev_resp_ready,
    output logic [N*CW-1:0]        udev_resp_cmd,
    output logic [N*AW-1:0]        udev_resp_dstaddr,
    output logic [N*AW-1:0]        udev_resp_srcaddr,
    output logic [N*DW-1:0]        udev_resp_data,
    output logic                   uhost_req_valid,
    input  logic                   uhost_req_ready,
    output logic [CW-1:0]          uhost_req_cmd,
    output logic [AW-1:0]          uhost_req_dstaddr,
    output logic [AW-1:0]          uhost_req_srcaddr,
    output logic [DW-1:0]          uhost_req_data,
    input  logic                   uhost_resp_valid,
    output logic                   uhost_resp_ready,
    input  logic [CW-1:0]          uhost_resp_cmd,
    input  logic [AW-1:0]          uhost_resp_dstaddr,
    input  logic [AW-1:0]          uhost_resp_srcaddr,
    input  logic [DW-1:0]          uhost_resp_data,
    output logic [$clog2(N)-1:0]   owner,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int PW = $clog2(N);

    arb_state_t     r_state;
    arb_state_t     w_state_nxt;
    logic [PW-1:0]  r_owner;
    logic [PW-1:0]  r_rr_ptr;
    logic [TOW-1:0] r_wdog;
    logic           r_timeout_err;

    logic [PW-1:0]  w_pick;
    logic           w_any;
    logic [PW-1:0]  w_owner_inc;
    logic [N-1:0]   w_owner_oh;
    logic           w_own_req_valid;
    logic           w_own_resp_ready;
    logic           w_req_hs;
    logic           w_resp_hs;
    logic           w_timeout;

    umi_rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .i_valid (udev_req_valid),
        .i_ptr   (r_rr_ptr),
        .o_idx   (w_pick),
        .o_any   (w_any)
    );

    assign w_owner_inc = (r_owner == PW'(N - 1)) ? '0 : (r_owner + PW'(1));

    always_comb begin
        w_owner_oh        = '0;
        w_own_req_valid   = 1'b0;
        w_own_resp_ready  = 1'b0;
        uhost_req_cmd     = '0;
        uhost_req_dstaddr = '0;
        uhost_req_srcaddr = '0;
        uhost_req_data    = '0;
        for (int i = 0; i < N; i++) begin
            if (r_owner == PW'(i)) begin
                w_owner_oh[i]     = 1'b1;
                w_own_req_valid   = udev_req_valid[i];
                w_own_resp_ready  = udev_resp_ready[i];
                uhost_req_cmd     = udev_req_cmd[i*CW +: CW];
                uhost_req_dstaddr = udev_req_dstaddr[i*AW +: AW];
                uhost_req_srcaddr = udev_req_srcaddr[i*AW +: AW];
                uhost_req_data    = udev_req_data[i*DW +: DW];
            end
        end
    end

    // Response payload fans out to every host; only the owner's valid qualifies it.
    assign udev_resp_cmd     = {N{uhost_resp_cmd}};
    assign udev_resp_dstaddr = {N{uhost_resp_dstaddr}};
    assign udev_resp_srcaddr = {N{uhost_resp_srcaddr}};
    assign udev_resp_data    = {N{uhost_resp_data}};

    always_comb begin
        w_state_nxt      = r_state;
        w_req_hs         = 1'b0;
        w_resp_hs        = 1'b0;
        w_timeout        = 1'b0;
        uhost_req_valid  = 1'b0;
        udev_req_ready   = '0;
        uhost_resp_ready = 1'b0;
        udev_resp_valid  = '0;
        case (r_state)
            IDLE: begin
                if (w_any) w_state_nxt = REQ;
            end
            REQ: begin
                uhost_req_valid = w_own_req_valid;
                udev_req_ready  = w_owner_oh & {N{uhost_req_ready}};
                if (w_own_req_valid && uhost_req_ready) begin
                    w_req_hs    = 1'b1;
                    w_state_nxt = (uhost_req_cmd[4:0] == UMI_REQ_POSTED) ? IDLE : WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                // A response arriving on the expiry cycle takes priority over the timeout.
                if (uhost_resp_valid) begin
                    w_state_nxt = RESP;
                end else if (r_wdog == TOW'(TIMEOUT - 1)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            RESP: begin
                udev_resp_valid  = w_owner_oh & {N{uhost_resp_valid}};
                uhost_resp_ready = w_own_resp_ready;
                if (uhost_resp_valid && w_own_resp_ready) begin
                    w_resp_hs   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state       <= IDLE;
            r_owner       <= '0;
            r_rr_ptr      <= '0;
            r_wdog        <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == IDLE) && w_any) r_owner <= w_pick;
            if (w_req_hs) r_rr_ptr <= w_owner_inc;
            if (w_timeout || w_resp_hs) begin
                r_wdog <= '0;
            end else if (r_state == WAIT_RESP) begin
                r_wdog <= r_wdog + TOW'(1);
            end
            if (w_timeout) r_timeout_err <= 1'b1;
        end
    end

    assign owner       = r_owner;
    assign busy        = (r_state != IDLE);
    assign timeout_err = r_timeout_err;

endmodule

`default_nettype wire
